mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter and sequencer that shares one 4-to-1 4-bit mux datapath among four requesters. It drives the mux select, grants one requester at a time for a bounded burst, and registers the selected data into a single-entry valid/ready output stage. It sits between four producer agents and one downstream consumer in the mux testbench environment.

## Interface
- `DW`, 4, data width per requester; matches the mux data width.
- `HOLD_MAX`, 4, maximum beats accepted per grant; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  4  per-requester level request; bit i holds while requester i has data.
- `a`, `b`, `c`, `d`  in  DW each  requester 0..3 data; must be stable while the matching `req` bit is high and `ack` is low.
- `gnt`  out  4  one-hot registered grant; all zero when no grant is active.
- `sel`  out  2  registered mux select, equal to the index of the granted requester.
- `ack`  out  4  combinational beat-accept; `ack[i]` = `gnt[i]` & `req[i]` & (!`y_valid` | `y_ready`).
- `y`  out  DW  registered selected data.
- `y_valid`  out  1  `y` holds a beat.
- `y_ready`  in  1  consumer accepts `y` this cycle.

## Operation
- FSM has two states: IDLE and GRANT. `ptr` (2 bits) is the round-robin start index; `cnt` (4 bits) counts beats in the current grant.
- IDLE, `req` != 0: pick the first set bit scanning `ptr`, `ptr`+1, … (mod 4). Set `gnt` one-hot and `sel`, clear `cnt`, and go to GRANT.
- IDLE, `req` == 0: stay in IDLE with `gnt` = 0. `sel` holds its last value.
- GRANT, accept (`ack[sel]` = 1): load `y` from the selected input (a/b/c/d per `sel`), set `y_valid`=1, and increment `cnt`.
- GRANT exit when either:
  - there is an accept with `cnt` == `HOLD_MAX`-1, or
  - `req[sel]` = 0.
  - On exit: `gnt` goes to 0, `ptr` goes to `sel`+1 mod 4, and the FSM returns to IDLE.
- GRANT with `req[sel]` = 1 but the output stalled (`y_valid` & !`y_ready`): hold state; `cnt` and `gnt` are unchanged.
- Output stage: when `y_ready` is high and there is no accept, `y_valid` clears. When `y_ready` and an accept occur together, `y` is replaced with no bubble.
- Non-granted `req` bits are ignored until the next IDLE decision.
- A `req` bit dropping mid-burst is legal and ends the grant.

## Timing
- Reset values: `gnt`=0, `sel`=0, `y`=0, `y_valid`=0, `ptr`=0, `cnt`=0, FSM=IDLE. `ack`=0 follows from `gnt`=0.
- Reset mid-burst: the grant is abandoned and a pending `y` is dropped regardless of `y_ready`.
- Latency:
  - `req` seen at edge E0 (in IDLE) → `gnt`/`sel` valid after E0.
  - First `ack` in the cycle after E0.
  - `y_valid` after E1 (2 edges from request).
- Throughput: 1 beat/cycle within a grant while `y_ready`=1.
- Grant switch: exactly one IDLE cycle between consecutive grants, so a switch costs one bubble.
- Arbitration fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,… with `HOLD_MAX` beats each.
- `ack` depends combinationally on `y_ready`; there is no combinational path from `req` to `y`.

## Configuration
- Macro: `MUX_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority (requester 0 highest, then 1, 2, 3). `ptr` is unused and held at 0. `HOLD_MAX` still bounds each burst.
- Undefined (default): round-robin as described above.

## Test plan
- Reset then single requester: `req`=4'b0100, `c`=4'hA, `y_ready`=1.
  - `gnt`=4'b0100 and `sel`=2 after 1 edge.
  - `y`=4'hA with `y_valid`=1 after 2 edges.
  - 4 beats, then 1 IDLE cycle, then a new grant to requester 2.
- All requesting, `y_ready`=1, `HOLD_MAX`=4:
  - grant order 0,1,2,3,0.
  - each grant carries 4 beats; exactly one bubble between grants.
- Backpressure: `y_ready`=0 for 3 cycles mid-burst.
  - `y` and `y_valid` hold; `ack`=0 and `cnt` frozen.
  - on release, beats resume with none lost or duplicated.
- Early release: requester 1 drops `req` after 2 beats while requester 3 is requesting.
  - grant ends; `ptr`=2; next grant goes to 3.
- Sync `rst` pulse mid-burst with `y_valid`=1 and `y_ready`=0.
  - next cycle: `y_valid`=0, `gnt`=0, `y`=0, and a subsequent arbitration starts from requester 0.
- With `MUX_ARB_FIXED_PRIO_EN`: `req`=4'b1001 held continuously.
  - requester 0 wins every arbitration; requester 3 is never granted.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with a
// single-entry valid/ready output register. Define MUX_ARB_FIXED_PRIO_EN for fixed priority.
module mux_rr_arbiter #(
    parameter int DW       = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic [3:0]    ack,
    output logic [DW-1:0] y,
    output logic          y_valid,
    input  logic          y_ready
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nx;
    logic [1:0]    ptr, ptr_nx, sel_nx, pick, idx;
    logic [3:0]    cnt, cnt_nx, gnt_nx;
    logic [DW-1:0] sel_data, y_nx;
    logic          y_valid_nx, accept, last_beat, found;

    // scan order starts at ptr; in fixed-priority builds ptr is pinned to 0
    always_comb begin
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign ack       = gnt & req & {4{!y_valid | y_ready}};
    assign accept    = |ack;
    assign last_beat = (cnt == 4'(HOLD_MAX - 1));

    always_comb begin
        case (sel)
            2'd0:    sel_data = a;
            2'd1:    sel_data = b;
            2'd2:    sel_data = c;
            default: sel_data = d;
        endcase
    end

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        sel_nx     = sel;
        ptr_nx     = ptr;
        cnt_nx     = cnt;
        y_nx       = y;
        y_valid_nx = y_valid;

        // output stage: accept replaces y with no bubble, otherwise drain on ready
        if (accept) begin
            y_nx       = sel_data;
            y_valid_nx = 1'b1;
        end else if (y_ready) begin
            y_valid_nx = 1'b0;
        end

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nx   = 4'b0001 << pick;
                    sel_nx   = pick;
                    cnt_nx   = 4'd0;
                    state_nx = GRANT;
                end
            end
            default: begin
                if (accept)
                    cnt_nx = cnt + 4'd1;
                if ((accept && last_beat) || !req[sel]) begin
                    gnt_nx   = 4'b0000;
                    state_nx = IDLE;
`ifdef MUX_ARB_FIXED_PRIO_EN
                    ptr_nx   = 2'd0;
`else
                    ptr_nx   = sel + 2'd1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            sel     <= 2'd0;
            ptr     <= 2'd0;
            cnt     <= 4'd0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            gnt     <= gnt_nx;
            sel     <= sel_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
            y       <= y_nx;
            y_valid <= y_valid_nx;
        end
    end

endmodule
